riscv_store_buffer: RTL and testbench
=====================================

Name: riscv_store_buffer

Overview:
- Posted-write buffer between the RISC-V CPU data-memory port and DRAM.
- CPU stores are queued in a small FIFO and retire to DRAM on cycles when the CPU is not reading, so stores do not contend with loads for the memory port.
- Loads see buffered data through store-to-load forwarding.
- The end-of-test dump request is held until the FIFO is empty, so the DRAM dump file contains every committed store.

Parameters:
- NB, 32, data and CPU address width.
- ADDR_W, 12, DRAM address width; the low ADDR_W bits of CPU_ADDR are used.
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CPU_RD  in  1  load request.
- CPU_WR  in  1  store request.
- CPU_ADDR  in  NB  byte address from the CPU.
- CPU_WDATA  in  NB  store data.
- CPU_RDATA  out  NB  load data (combinational).
- STALL  out  1  CPU must hold its request (combinational).
- DUMP_REQ  in  1  end-of-simulation dump request.
- MEM_RD  out  1  DRAM read strobe.
- MEM_WR  out  1  DRAM write strobe.
- MEM_ADDR  out  ADDR_W  DRAM address.
- MEM_WDATA  out  NB  DRAM write data.
- MEM_RDATA  in  NB  DRAM read data; combinational read, same cycle.
- DUMP_OUT  out  1  DRAM dump strobe.

Behaviour:
- Reset (async):
  - Head, tail and count cleared.
  - FSM to IDLE; pending-dump flag cleared.
  - DUMP_OUT=0, STALL=0, MEM_RD=MEM_WR=0, MEM_ADDR=0, MEM_WDATA=0.
  - Buffered stores are discarded, including on reset mid-drain.
- FIFO:
  - Storage: DEPTH × {ADDR_W addr, NB data}.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Enqueue:
  - Condition: CPU_WR=1, STALL=0.
  - Action: {CPU_ADDR[ADDR_W-1:0], CPU_WDATA} written at tail on the rising edge; 1-cycle latency.
- STALL:
  - STALL = (CPU_WR & full) | (FSM≠IDLE & (CPU_RD|CPU_WR)).
  - STALL is conservative: it is still asserted when full even if a drain happens in the same cycle.
- Memory port priority:
  - A CPU_RD that is not stalled owns the port: MEM_RD=1, MEM_ADDR=CPU_ADDR[ADDR_W-1:0], and no drain occurs that cycle.
  - Otherwise, if not empty: MEM_WR=1, MEM_ADDR/MEM_WDATA = head entry, and head advances at the edge.
  - When the port is idle, MEM_ADDR and MEM_WDATA are driven to 0.
- Simultaneous enqueue and drain: both pointers advance and count is unchanged.
- CPU_RD and CPU_WR asserted together: the read takes the port, and the write still enqueues if not full.
- Forwarding:
  - On CPU_RD, compare the ADDR_W-bit address against all valid entries.
  - If there is a match, CPU_RDATA = data of the youngest matching entry; otherwise CPU_RDATA = MEM_RDATA.
  - Comparison is on full words; no byte-enable merging.
- Dump FSM:
  - IDLE: DUMP_REQ=1 → DRAIN.
  - DRAIN: STALL on any CPU request; drain one entry per cycle. When count==0, go to DUMP.
  - DUMP: DUMP_OUT=1 for exactly one cycle, then go to IDLE.
  - If DUMP_REQ is asserted again while in DRAIN or DUMP, it is latched and the sequence repeats once after returning to IDLE.
  - DUMP_REQ while already empty: IDLE→DRAIN→DUMP; DUMP_OUT rises 2 cycles after DUMP_REQ is sampled.

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined: store-to-load forwarding as described above.
- Undefined:
  - A CPU_RD that matches any buffered entry asserts STALL and does not issue MEM_RD.
  - Drain proceeds in those cycles; once no entry matches, the read issues normally and CPU_RDATA = MEM_RDATA.
  - The comparators are still present; the forwarding mux is removed.

Test Plan:
- Reset mid-operation:
  - Stimulus: 3 stores queued, assert RST for 1 cycle mid-drain.
  - Response: count=0, MEM_WR=0 immediately (async), and no further DRAM writes.
- Back-to-back stores with no reads:
  - Stimulus: stores 0x11,0x22,0x33,0x44 to addresses 0x010,0x014,0x018,0x01C.
  - Response: DRAM receives the writes in order, one per cycle, each 1 cycle after enqueue; STALL is never asserted.
- Full buffer:
  - Stimulus: CPU_RD held high while 5 stores are issued, DEPTH=4.
  - Response: the 5th store sees STALL=1 until the first read-free cycle, then enqueues; FIFO order is preserved.
- Forwarding (with STORE_BUF_FWD_EN):
  - Stimulus: store 0xAAAA_0001 then 0xBBBB_0002 to 0x040, then an immediate load from 0x040 while both are still buffered.
  - Response: CPU_RDATA=0xBBBB_0002 in the same cycle, and MEM_RD=1 to 0x040.
- Matching load without STORE_BUF_FWD_EN:
  - Stimulus: same sequence as the forwarding test.
  - Response: STALL=1 for 2 cycles while both entries drain, then the load returns 0xBBBB_0002 from DRAM.
- Dump:
  - Stimulus: 3 buffered stores, then a DUMP_REQ pulse.
  - Response: 3 MEM_WR cycles, then DUMP_OUT=1 for exactly 1 cycle; CPU requests see STALL=1 throughout.
  - Stimulus: DUMP_REQ re-pulsed during DRAIN.
  - Response: exactly one additional DUMP_OUT pulse.

Source files
------------

// File: rtl/riscv_store_buffer_if.sv
// Bundle of CPU-side and DRAM-side signals for the store buffer.
//   master : CPU/DRAM environment. Drives cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dump_req and
//            mem_rdata. Observes cpu_rdata, stall, mem_rd, mem_wr, mem_addr, mem_wdata and
//            dump_out.
//   slave  : the store buffer, with the opposite directions.
interface riscv_store_buffer_if #(
  parameter int unsigned NB     = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [NB-1:0]     cpu_addr;
  logic [NB-1:0]     cpu_wdata;
  logic [NB-1:0]     cpu_rdata;
  logic              stall;
  logic              dump_req;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_wdata;
  logic [NB-1:0]     mem_rdata;
  logic              dump_out;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dump_req, mem_rdata,
    input  cpu_rdata, stall, mem_rd, mem_wr, mem_addr, mem_wdata, dump_out
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dump_req, mem_rdata,
    output cpu_rdata, stall, mem_rd, mem_wr, mem_addr, mem_wdata, dump_out
  );
endinterface

// File: rtl/riscv_store_buffer.sv
// Posted-write buffer between the CPU data port and DRAM.
// Stores are queued in a DEPTH-entry FIFO. They retire to DRAM on cycles where no load owns the
// memory port. A dump request first drains the FIFO, then pulses dump_out for one cycle.
//
// Ports:
//   clk : system clock, rising edge.
//   rst : asynchronous, active-high reset.
//   bus : riscv_store_buffer_if.slave. Carries the CPU load/store request and response
//         (stall and cpu_rdata are combinational), dump_req/dump_out, and the DRAM port
//         (mem_rdata is a same-cycle read).
//
// Build option:
//   STORE_BUF_FWD_EN defined   : a load that hits buffered entries returns the youngest
//                                matching data directly from the buffer.
//   STORE_BUF_FWD_EN undefined : a load that hits buffered entries stalls until those
//                                entries have drained, then reads DRAM.
module riscv_store_buffer #(
  parameter int unsigned NB     = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  riscv_store_buffer_if.slave bus
);

  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic [1:0] {StIdle, StDrain, StDump} state_e;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [NB-1:0]     data_q [DEPTH];
  ptr_t              head_q, tail_q;
  logic [PTR_W:0]    cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              pend_q, pend_d;

  logic              full, empty, hit, rd_block;
  logic              rd_req, wr_req, stall, rd_go, enq, deq;
  logic [ADDR_W-1:0] cpu_a;
  logic              unused_addr_hi;
`ifdef STORE_BUF_FWD_EN
  logic [NB-1:0]     hit_data;
`endif

  assign cpu_a          = bus.cpu_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^bus.cpu_addr[NB-1:ADDR_W];
  assign full           = (cnt_q == FULL_CNT);
  assign empty          = (cnt_q == '0);

  // Scan entries from oldest to youngest so the last match wins (youngest store).
  always_comb begin
    hit = 1'b0;
`ifdef STORE_BUF_FWD_EN
    hit_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((i < 32'(cnt_q)) && (addr_q[head_q + ptr_t'(i)] == cpu_a)) begin
        hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
        hit_data = data_q[head_q + ptr_t'(i)];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign rd_block = 1'b0;
`else
  assign rd_block = hit;
`endif

  // Requests are ignored while reset is held so every output reads back as idle.
  assign rd_req = bus.cpu_rd & ~rst;
  assign wr_req = bus.cpu_wr & ~rst;

  // Full-stall does not look at a concurrent drain; this keeps stall off the drain path.
  assign stall = (wr_req & full) | ((state_q != StIdle) & (rd_req | wr_req)) |
                 (rd_req & rd_block);
  assign rd_go = rd_req & ~stall;
  assign enq   = wr_req & ~stall;
  assign deq   = ~rd_go & ~empty & ~rst;

  always_comb begin
    bus.stall     = stall;
    bus.mem_rd    = rd_go;
    bus.mem_wr    = deq;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (rd_go) begin
      bus.mem_addr = cpu_a;
    end else if (deq) begin
      bus.mem_addr  = addr_q[head_q];
      bus.mem_wdata = data_q[head_q];
    end
`ifdef STORE_BUF_FWD_EN
    bus.cpu_rdata = hit ? hit_data : bus.mem_rdata;
`else
    bus.cpu_rdata = bus.mem_rdata;
`endif
    bus.dump_out  = ~rst & (state_q == StDump);
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Dump sequencer. A request arriving mid-sequence is remembered and replayed once.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (bus.dump_req | pend_q) begin
          state_d = StDrain;
          pend_d  = 1'b0;
        end
      end
      StDrain: begin
        if (bus.dump_req) pend_d = 1'b1;
        if (empty) state_d = StDump;
      end
      StDump: begin
        if (bus.dump_req) pend_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      state_q <= StIdle;
      pend_q  <= 1'b0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Entry storage needs no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= cpu_a;
      data_q[tail_q] <= bus.cpu_wdata;
    end
  end

endmodule

// File: tb/tb_riscv_store_buffer.sv
// Bench for riscv_store_buffer.
// Stimulus pushes the expected DRAM writes, load results and dump pulses into queues. A monitor
// runs on the falling edge and compares every event the DUT presents against those queues.
module tb_riscv_store_buffer;
  localparam int unsigned NB     = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 4;
`ifdef STORE_BUF_FWD_EN
  localparam int FWD_STALLS = 0;
`else
  localparam int FWD_STALLS = 2;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [NB-1:0]     data;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_dumps = 0;
  logic prev_dump = 1'b0;
  txn_t exp_wr[$];
  txn_t exp_rd[$];
  logic [NB-1:0] dram [4096];

  always #5 clk = ~clk;

  riscv_store_buffer_if #(.NB(NB), .ADDR_W(ADDR_W)) bus ();

  riscv_store_buffer #(.NB(NB), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // DRAM model: combinational read, write captured mid-cycle.
  assign bus.mem_rdata = dram[bus.mem_addr];

  initial begin
    for (int i = 0; i < 4096; i++) dram[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_wr) dram[bus.mem_addr] = bus.mem_wdata;
    end
  end

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Present one CPU request and hold it until accepted; returns the number of stalled cycles.
  task automatic do_op(input logic rd, input logic wr, input logic [NB-1:0] addr,
                       input logic [NB-1:0] wdata, input logic [NB-1:0] rexp,
                       output int stalls);
    int n;
    if (rd) exp_rd.push_back('{addr: addr[ADDR_W-1:0], data: rexp});
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (bus.stall && n < 64) begin
      n++;
      @(negedge clk);
    end
    if (n == 64) check("op_accept_timeout", bus.stall, 1'b0);
    stalls = n;
    @(posedge clk);
    #1;
    if (wr) exp_wr.push_back('{addr: addr[ADDR_W-1:0], data: wdata});
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  // Monitor
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_wr) begin
          check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("wr_data", bus.mem_wdata, e.data);
          end
        end
        if (bus.cpu_rd && !bus.stall) begin
          check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
          if (exp_rd.size() != 0) begin
            e = exp_rd.pop_front();
            check("rd_mem_rd", 32'(bus.mem_rd), 32'd1);
            check("rd_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("rd_data", bus.cpu_rdata, e.data);
          end
        end
        if (bus.dump_out) begin
          check("dump_single_cycle", 32'(prev_dump), 32'd0);
          check("dump_expected", 32'(exp_dumps != 0), 32'd1);
          check("dump_after_drain", 32'(exp_wr.size()), 32'd0);
          if (exp_dumps != 0) exp_dumps--;
        end
        prev_dump = bus.dump_out;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  // Stimulus
  initial begin
    int st;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dump_req  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_dump_out", 32'(bus.dump_out), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back stores, no reads: each retires the cycle after it is enqueued.
    for (int k = 0; k < 4; k++) begin
      do_op(1'b0, 1'b1, 32'h10 + 32'(4 * k), 32'h11 * 32'(k + 1), '0, st);
      check("b2b_stall", 32'(st), 32'd0);
    end
    @(posedge clk);
    #1;
    check("b2b_drained", 32'(exp_wr.size()), 32'd0);

    // Load plus store every cycle: the port never frees, so the fifth store hits full.
    for (int k = 0; k < 5; k++) begin
      do_op(1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'hF0 + 32'(k), '0, st);
      check("full_stall", 32'(st), (k == 4) ? 32'd1 : 32'd0);
    end
    repeat (6) @(posedge clk);
    #1;
    check("full_drained", 32'(exp_wr.size()), 32'd0);

    // Two older entries keep both 0x040 stores buffered when the load arrives.
    do_op(1'b1, 1'b1, 32'h300, 32'hC0, '0, st);
    do_op(1'b1, 1'b1, 32'h304, 32'hC1, '0, st);
    do_op(1'b0, 1'b1, 32'h040, 32'hAAAA_0001, '0, st);
    check("fwd_st1_stall", 32'(st), 32'd0);
    do_op(1'b0, 1'b1, 32'h040, 32'hBBBB_0002, '0, st);
    check("fwd_st2_stall", 32'(st), 32'd0);
    do_op(1'b1, 1'b0, 32'h040, '0, 32'hBBBB_0002, st);
    check("fwd_ld_stall", 32'(st), 32'(FWD_STALLS));
    repeat (4) @(posedge clk);
    #1;
    do_op(1'b1, 1'b0, 32'h040, '0, 32'hBBBB_0002, st);
    check("dram_ld_stall", 32'(st), 32'd0);

    // Dump with three buffered stores; a store issued during the sequence waits it out.
    for (int k = 0; k < 3; k++) do_op(1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'hD0 + 32'(k), '0, st);
    exp_dumps++;
    bus.dump_req = 1'b1;
    @(posedge clk);
    #1;
    bus.dump_req = 1'b0;
    do_op(1'b0, 1'b1, 32'h210, 32'hD3, '0, st);
    check("dump_stall", 32'(st), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("dump_done", 32'(exp_dumps), 32'd0);

    // Second request during the drain replays the sequence exactly once.
    for (int k = 0; k < 3; k++) do_op(1'b1, 1'b1, 32'h220 + 32'(4 * k), 32'hE0 + 32'(k), '0, st);
    exp_dumps += 2;
    bus.dump_req = 1'b1;
    @(posedge clk);
    #1;
    bus.dump_req = 1'b0;
    @(posedge clk);
    #1;
    bus.dump_req = 1'b1;
    @(posedge clk);
    #1;
    bus.dump_req = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("repulse_done", 32'(exp_dumps), 32'd0);

    // Dump while empty: dump_out is high two cycles after the request cycle.
    exp_dumps++;
    bus.dump_req = 1'b1;
    @(negedge clk);
    check("empty_dump_c0", 32'(bus.dump_out), 32'd0);
    @(posedge clk);
    #1;
    bus.dump_req = 1'b0;
    @(negedge clk);
    check("empty_dump_c1", 32'(bus.dump_out), 32'd0);
    @(negedge clk);
    check("empty_dump_c2", 32'(bus.dump_out), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("empty_dump_done", 32'(exp_dumps), 32'd0);

    // Reset while the second of three entries is on the port.
    for (int k = 0; k < 3; k++) do_op(1'b1, 1'b1, 32'h500 + 32'(4 * k), 32'h5A0 + 32'(k), '0, st);
    @(posedge clk);
    #1;
    check("pre_reset_wr", 32'(bus.mem_wr), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("async_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    exp_wr.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_kept_500", dram[12'h500], 32'h5A0);
    check("rst_dropped_504", dram[12'h504], 32'd0);
    check("rst_dropped_508", dram[12'h508], 32'd0);
    do_op(1'b0, 1'b1, 32'h600, 32'h66, '0, st);
    check("post_rst_stall", 32'(st), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    check("end_wr_queue", 32'(exp_wr.size()), 32'd0);
    check("end_rd_queue", 32'(exp_rd.size()), 32'd0);
    check("end_dumps", 32'(exp_dumps), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
